// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: state codes, opcodes and
// the mux/ALU encodings driven onto the datapath.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_LUI    = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;
  localparam logic [1:0] M2R_UPPER  = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_VECTOR = 2'd3;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_SLT   = 2'd3;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
  endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier: maps an opcode to the state that executes it and flags
// opcodes this build does not implement. Purely combinational.
module mc_opdecode
  import mc_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [5:0] op,
  output state_t     next_state,
  output logic       legal
);

  logic ext_en;
  assign ext_en = (EXT_OPS != 0);

  always_comb begin
    legal      = 1'b1;
    next_state = S_TRAP;
    case (op)
      OP_LW, OP_SW:     next_state = S_MADDR;
      OP_R:             next_state = S_REX;
      OP_BEQ:           next_state = S_BR;
      OP_J:             next_state = S_JMP;
      OP_ADDI, OP_SLTI: begin
        if (ext_en) next_state = S_IEX;
        else        legal      = 1'b0;
      end
      OP_JAL: begin
        if (ext_en) next_state = S_JAL;
        else        legal      = 1'b0;
      end
      OP_BNE: begin
        if (ext_en) next_state = S_BR;
        else        legal      = 1'b0;
      end
      OP_LUI: begin
        if (ext_en) next_state = S_LUI;
        else        legal      = 1'b0;
      end
      default:          legal      = 1'b0;
    endcase
    if (!legal) next_state = S_TRAP;
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM. Outputs are decoded from the state
// register and the opcode captured in DECODE.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXT_OPS       = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       exc
);

  localparam logic [3:0] TIMEOUT_CNT = TIMEOUT[3:0];

  state_t     state_q;
  logic [5:0] op_q;
  logic [3:0] wait_cnt;
  state_t     dec_next;
  logic       dec_legal;
  state_t     mem_next;
  logic       mem_done;
  logic       time_up;

  mc_opdecode #(
    .EXT_OPS(EXT_OPS)
  ) u_opdecode (
    .op        (op),
    .next_state(dec_next),
    .legal     (dec_legal)
  );

  // Memory handshake: an access completes in any cycle where mem_ready is
  // high, or every cycle when the handshake is disabled. A completing cycle
  // beats a timeout that falls in the same cycle.
  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;
  assign time_up  = (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    mem_next = S_FETCH;
    case (state_q)
      S_FETCH: mem_next = S_DECODE;
      S_MRD:   mem_next = S_MWB;
      default: mem_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      // Any step that is not a stall leaves the counter clear, so each
      // memory state is entered with a count of zero.
      wait_cnt <= '0;
      case (state_q)
        S_FETCH, S_MRD, S_MWR: begin
          if (mem_done)     state_q <= mem_next;
          else if (time_up) state_q <= S_TRAP;
          else              wait_cnt <= wait_cnt + 4'd1;
        end
        S_DECODE: begin
          op_q    <= op;
          state_q <= dec_legal ? dec_next : S_TRAP;
        end
        S_MADDR: begin
          if (op_q == OP_LW)      state_q <= S_MRD;
          else if (op_q == OP_SW) state_q <= S_MWR;
          else                    state_q <= S_FETCH;
        end
        S_REX:   state_q <= S_RWB;
        S_IEX:   state_q <= S_IWB;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    RegDst      = DST_RT;
    MemToReg    = M2R_ALUOUT;
    ALUSrcB     = SRCB_REG;
    ALUop       = ALU_ADD;
    PCSource    = PCS_ALU;
    exc         = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC load only on the completing fetch cycle, never in reset.
        IRWrite = rst_n & mem_done;
        PCWrite = rst_n & mem_done;
      end
      S_DECODE: ALUSrcB = SRCB_BOFF;
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemToReg = M2R_MDR;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = DST_RD;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        BranchNE    = (op_q == OP_BNE);
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        RegDst   = DST_R31;
        MemToReg = M2R_PC;
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: RegWrite = 1'b1;
      S_LUI: begin
        RegWrite = 1'b1;
        MemToReg = M2R_UPPER;
      end
      S_TRAP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_VECTOR;
        exc      = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
